// File: rtl/string_match_scheduler.sv
// Sequencer for a bank of string comparators: owns the shadow/active string table,
// frames each packet (clear, stream, drain) and holds a per-slot verdict until consumed.
module string_match_scheduler #(
    parameter int NUM_SLOTS    = 4,
    parameter int DRAIN_CYCLES = 2,
    parameter int SLOT_W       = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_cfg_wr,
    input  logic [SLOT_W-1:0]        i_cfg_slot,
    input  logic [4:0]               i_cfg_idx,
    input  logic [7:0]               i_cfg_data,
    input  logic                     i_cfg_commit,
    output logic                     o_cfg_pending,
    output logic                     o_cfg_err,
    input  logic                     i_in_valid,
    input  logic                     i_in_sop,
    input  logic                     i_in_eop,
    input  logic [31:0]              i_in_data,
    output logic                     o_in_ready,
    output logic                     o_comp_clear,
    output logic [31:0]              o_comp_data,
    output logic [NUM_SLOTS*136-1:0] o_comp_flagged_string,
    output logic [NUM_SLOTS*5-1:0]   o_comp_strlen,
    input  logic [NUM_SLOTS-1:0]     i_comp_match,
    output logic                     o_res_valid,
    input  logic                     i_res_ready,
    output logic [NUM_SLOTS-1:0]     o_res_match,
    output logic                     o_res_any,
    output logic                     o_res_gap_err
);
    localparam int CNT_W = $clog2(DRAIN_CYCLES) + 1;

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STREAM, S_DRAIN, S_REPORT} state_t;

    state_t r_state;
    state_t w_state_next;

    logic [NUM_SLOTS-1:0][16:0][7:0] r_sh_str;
    logic [NUM_SLOTS-1:0][16:0][7:0] r_act_str;
    logic [NUM_SLOTS-1:0][4:0]       r_sh_len;
    logic [NUM_SLOTS-1:0][4:0]       r_act_len;
    logic                            r_pending;
    logic                            r_cfg_err;
    logic                            r_gap;
    logic                            r_first;
    logic [CNT_W-1:0]                r_drain_cnt;
    logic [NUM_SLOTS-1:0]            r_res_match;
    logic                            r_res_gap;

    logic                 w_slot_ok;
    logic                 w_wr_bad;
    logic                 w_wr_byte;
    logic                 w_wr_len;
    logic                 w_apply;
    logic                 w_hs;
    logic [NUM_SLOTS-1:0] w_enable;

    assign w_slot_ok = (32'(i_cfg_slot) < NUM_SLOTS);
    assign w_wr_bad  = !w_slot_ok || ((i_cfg_idx == 5'd17) && (i_cfg_data > 8'd17));
    assign w_wr_byte = i_cfg_wr && w_slot_ok && (i_cfg_idx <= 5'd16);
    assign w_wr_len  = i_cfg_wr && !w_wr_bad && (i_cfg_idx == 5'd17);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            assign o_comp_flagged_string[gi*136 +: 136] = r_act_str[gi];
            assign o_comp_strlen[gi*5 +: 5]             = r_act_len[gi];
            assign w_enable[gi] = (r_act_len[gi] != 5'd0) && (r_act_len[gi] <= 5'd17);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_in_ready   = 1'b0;
        o_comp_clear = 1'b0;
        o_comp_data  = 32'd0;
        w_hs         = 1'b0;
        w_apply      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A pending commit always wins over a waiting SOP
                if (r_pending) begin
                    w_apply = 1'b1;
                end else if (i_in_valid && i_in_sop) begin
                    w_state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                o_comp_clear = 1'b1;
                w_state_next = S_STREAM;
            end
            S_STREAM: begin
                o_in_ready = 1'b1;
                if (i_in_valid) begin
                    w_hs        = 1'b1;
                    o_comp_data = i_in_data;
                    if (i_in_eop) begin
                        w_state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (r_drain_cnt == '0) begin
                    w_state_next = S_REPORT;
                end
            end
            S_REPORT: begin
                if (i_res_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_str  <= '0;
            r_sh_len  <= '0;
            r_act_str <= '0;
            r_act_len <= '0;
            r_pending <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= i_cfg_wr && w_wr_bad;
            if (w_wr_byte) begin
                r_sh_str[i_cfg_slot][i_cfg_idx] <= i_cfg_data;
            end
            if (w_wr_len) begin
                r_sh_len[i_cfg_slot] <= i_cfg_data[4:0];
            end
            if (w_apply) begin
                r_act_str <= r_sh_str;
                r_act_len <= r_sh_len;
                r_pending <= 1'b0;
            end else if (i_cfg_commit) begin
                r_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gap       <= 1'b0;
            r_first     <= 1'b0;
            r_drain_cnt <= '0;
            r_res_match <= '0;
            r_res_gap   <= 1'b0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_gap   <= 1'b0;
                    r_first <= 1'b1;
                end
                S_STREAM: begin
                    if (w_hs) begin
                        r_first <= 1'b0;
                        // SOP after the first word means the upstream framing broke
                        if (i_in_sop && !r_first) begin
                            r_gap <= 1'b1;
                        end
                        if (i_in_eop) begin
                            r_drain_cnt <= CNT_W'(DRAIN_CYCLES - 1);
                        end
                    end else begin
                        r_gap <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (r_drain_cnt == '0) begin
                        r_res_match <= i_comp_match & w_enable;
                        r_res_gap   <= r_gap;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_cfg_pending = r_pending;
    assign o_cfg_err     = r_cfg_err;
    assign o_res_valid   = (r_state == S_REPORT);
    assign o_res_match   = (r_state == S_REPORT) ? r_res_match : '0;
    assign o_res_gap_err = (r_state == S_REPORT) && r_res_gap;
    assign o_res_any     = |o_res_match;

endmodule

// File: tb/tb_string_match_scheduler.sv
// Directed bench for string_match_scheduler: table programming, commit timing,
// packet framing, gap detection, verdict hold and async reset.
module tb_string_match_scheduler;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cfg_wr = 1'b0;
    logic [1:0]   cfg_slot = '0;
    logic [4:0]   cfg_idx = '0;
    logic [7:0]   cfg_data = '0;
    logic         cfg_commit = 1'b0;
    logic         cfg_pending, cfg_err;
    logic         in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
    logic [31:0]  in_data = '0;
    logic         in_ready, comp_clear;
    logic [31:0]  comp_data;
    logic [543:0] comp_flagged_string;
    logic [19:0]  comp_strlen;
    logic [3:0]   comp_match = '0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [3:0]   res_match;
    logic         res_any, res_gap_err;

    // Second instance with a non-power-of-two slot count to reach an out-of-range slot
    logic         b_cfg_wr = 1'b0;
    logic [1:0]   b_cfg_slot = '0;
    logic         b_cfg_pending, b_cfg_err, b_in_ready, b_comp_clear;
    logic [31:0]  b_comp_data;
    logic [407:0] b_comp_flagged_string;
    logic [14:0]  b_comp_strlen;
    logic         b_res_valid, b_res_any, b_res_gap_err;
    logic [2:0]   b_res_match;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] pkt [0:7];
    int first_hs_cyc;
    int cyc;
    logic [3:0] held_match;

    always #5 clk = ~clk;

    string_match_scheduler #(.NUM_SLOTS(4), .DRAIN_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .i_cfg_wr(cfg_wr), .i_cfg_slot(cfg_slot), .i_cfg_idx(cfg_idx), .i_cfg_data(cfg_data),
        .i_cfg_commit(cfg_commit), .o_cfg_pending(cfg_pending), .o_cfg_err(cfg_err),
        .i_in_valid(in_valid), .i_in_sop(in_sop), .i_in_eop(in_eop), .i_in_data(in_data),
        .o_in_ready(in_ready), .o_comp_clear(comp_clear), .o_comp_data(comp_data),
        .o_comp_flagged_string(comp_flagged_string), .o_comp_strlen(comp_strlen),
        .i_comp_match(comp_match), .o_res_valid(res_valid), .i_res_ready(res_ready),
        .o_res_match(res_match), .o_res_any(res_any), .o_res_gap_err(res_gap_err)
    );

    string_match_scheduler #(.NUM_SLOTS(3), .DRAIN_CYCLES(2)) dut_b (
        .clk(clk), .rst(rst),
        .i_cfg_wr(b_cfg_wr), .i_cfg_slot(b_cfg_slot), .i_cfg_idx(cfg_idx), .i_cfg_data(cfg_data),
        .i_cfg_commit(1'b0), .o_cfg_pending(b_cfg_pending), .o_cfg_err(b_cfg_err),
        .i_in_valid(1'b0), .i_in_sop(1'b0), .i_in_eop(1'b0), .i_in_data(32'd0),
        .o_in_ready(b_in_ready), .o_comp_clear(b_comp_clear), .o_comp_data(b_comp_data),
        .o_comp_flagged_string(b_comp_flagged_string), .o_comp_strlen(b_comp_strlen),
        .i_comp_match(3'b000), .o_res_valid(b_res_valid), .i_res_ready(1'b0),
        .o_res_match(b_res_match), .o_res_any(b_res_any), .o_res_gap_err(b_res_gap_err)
    );

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int slot, input int idx, input int data);
        cfg_wr   = 1'b1;
        cfg_slot = slot[1:0];
        cfg_idx  = idx[4:0];
        cfg_data = data[7:0];
        tick;
        cfg_wr = 1'b0;
    endtask

    task automatic do_commit;
        cfg_commit = 1'b1;
        tick;
        cfg_commit = 1'b0;
        check_val("pending_set", cfg_pending, 1);
        tick;
        check_val("pending_clr", cfg_pending, 0);
    endtask

    // Drives one packet from the IDLE SOP cycle through the EOP handshake.
    task automatic send_packet(input int n, input int bubble, input bit stray_sop, input int commit_at);
        int i = 0;
        int guard = 0;
        bit bubbled = 1'b0;
        first_hs_cyc = -1;
        while (i < n && guard < 40) begin
            cfg_commit = (i == commit_at);
            if (i > 0 && i == bubble && !bubbled) begin
                in_valid = 1'b0;
                bubbled  = 1'b1;
            end else begin
                in_valid = 1'b1;
                in_sop   = (i == 0) || (stray_sop && i == n - 1);
                in_eop   = (i == n - 1);
                in_data  = pkt[i];
            end
            #1;
            if (in_ready) begin
                if (in_valid) begin
                    if (i == 0) first_hs_cyc = guard;
                    check_val("comp_data", comp_data, pkt[i]);
                    i++;
                end else begin
                    check_val("bubble_data", comp_data, 0);
                end
            end
            @(posedge clk);
            #1;
            guard++;
        end
        cfg_commit = 1'b0;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0;
        if (guard >= 40) check_val("pkt_timeout", 1, 0);
    endtask

    task automatic wait_result;
        cyc = 0;
        while (!res_valid && cyc < 20) begin
            check_val("drain_data", comp_data, 0);
            tick;
            cyc++;
        end
        check_val("eop_to_res", cyc, 2);
    endtask

    task automatic accept_result;
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        check_val("res_valid_drop", res_valid, 0);
        check_val("res_match_zero", res_match, 0);
    endtask

    initial begin
        tick;
        check_val("rst_ready", in_ready, 0);
        check_val("rst_res_valid", res_valid, 0);
        check_val("rst_pending", cfg_pending, 0);
        check_val("rst_strlen", comp_strlen, 0);
        check_val("rst_string", |comp_flagged_string, 0);
        check_val("rst_clear", comp_clear, 0);
        rst = 1'b0;
        tick;

        // T1: slot0 = "EVIL", packet splits it across two words
        cfg_write(0, 13, 8'h45); cfg_write(0, 14, 8'h56);
        cfg_write(0, 15, 8'h49); cfg_write(0, 16, 8'h4C);
        cfg_write(0, 17, 4);
        do_commit;
        check_val("t1_strlen0", comp_strlen[4:0], 4);
        check_val("t1_string0", comp_flagged_string[13*8 +: 32], 32'h4C495645);
        pkt[0] = 32'h56457878; pkt[1] = 32'h78784C49;
        comp_match = 4'b1111;
        send_packet(2, -1, 1'b0, -1);
        check_val("t1_sop_lat", first_hs_cyc, 2);
        wait_result;
        check_val("t1_match", res_match, 4'b0001);
        check_val("t1_any", res_any, 1);
        check_val("t1_gap", res_gap_err, 0);
        $display("pkt T1 res_match=%b any=%b gap=%b", res_match, res_any, res_gap_err);
        accept_result;

        // T2: every slot disabled, one-word packet, comparators all asserting
        cfg_write(0, 17, 0);
        do_commit;
        pkt[0] = 32'hDEADBEEF;
        send_packet(1, -1, 1'b0, -1);
        wait_result;
        check_val("t2_match", res_match, 0);
        check_val("t2_any", res_any, 0);
        $display("pkt T2 res_match=%b any=%b", res_match, res_any);
        accept_result;

        // T3: strlen range and slot range rejection
        cfg_write(1, 17, 5);
        check_val("t3_ok_err", cfg_err, 0);
        cfg_write(1, 17, 18);
        check_val("t3_err_pulse", cfg_err, 1);
        tick;
        check_val("t3_err_drop", cfg_err, 0);
        cfg_write(1, 20, 8'hAA);
        check_val("t3_idx_ignored", cfg_err, 0);
        do_commit;
        check_val("t3_strlen1", comp_strlen[9:5], 5);
        b_cfg_wr = 1'b1; b_cfg_slot = 2'd3; cfg_idx = 5'd0; cfg_data = 8'h55;
        tick;
        b_cfg_slot = 2'd2;
        check_val("t3_slot_err", b_cfg_err, 1);
        tick;
        b_cfg_wr = 1'b0;
        check_val("t3_slot_ok", b_cfg_err, 0);
        $display("cfg T3 range checks done");

        // T4: commit during STREAM must not reach the active table before REPORT exits
        cfg_write(0, 17, 4);
        do_commit;
        cfg_write(0, 17, 0);
        pkt[0] = 32'h11111111; pkt[1] = 32'h22222222; pkt[2] = 32'h33333333;
        send_packet(3, -1, 1'b0, 1);
        wait_result;
        check_val("t4_match", res_match, 4'b0011);
        check_val("t4_pending_rep", cfg_pending, 1);
        check_val("t4_active_held", comp_strlen[4:0], 4);
        $display("pkt T4 res_match=%b pending=%b", res_match, cfg_pending);
        accept_result;
        check_val("t4_pending_idle", cfg_pending, 1);
        tick;
        check_val("t4_pending_drop", cfg_pending, 0);
        check_val("t4_active_new", comp_strlen[4:0], 0);

        // T5: bubble mid-packet, then stray SOP
        comp_match = 4'b0010;
        send_packet(3, 1, 1'b0, -1);
        wait_result;
        check_val("t5_gap_bubble", res_gap_err, 1);
        check_val("t5_match", res_match, 4'b0010);
        $display("pkt T5a res_match=%b gap=%b", res_match, res_gap_err);
        accept_result;
        pkt[0] = 32'hAAAA5555; pkt[1] = 32'h5555AAAA;
        send_packet(2, -1, 1'b1, -1);
        wait_result;
        check_val("t5_gap_sop", res_gap_err, 1);
        $display("pkt T5b res_match=%b gap=%b", res_match, res_gap_err);
        accept_result;

        // T6: verdict holds under backpressure, then reset mid-stream
        comp_match = 4'b0010;
        send_packet(2, -1, 1'b0, -1);
        wait_result;
        held_match = res_match;
        check_val("t6_match", held_match, 4'b0010);
        comp_match = 4'b0000;
        in_valid = 1'b1; in_sop = 1'b1; in_data = 32'hCAFEF00D;
        for (int k = 0; k < 10; k++) begin
            tick;
            check_val("t6_hold_valid", res_valid, 1);
            check_val("t6_hold_match", res_match, 4'b0010);
            check_val("t6_hold_ready", in_ready, 0);
        end
        in_valid = 1'b0; in_sop = 1'b0;
        $display("pkt T6 held res_match=%b", res_match);
        accept_result;
        in_valid = 1'b1; in_sop = 1'b1; in_data = 32'h12345678;
        tick;
        tick;
        check_val("t6_stream_ready", in_ready, 1);
        check_val("t6_stream_data", comp_data, 32'h12345678);
        rst = 1'b1;
        tick;
        check_val("t6_rst_ready", in_ready, 0);
        check_val("t6_rst_data", comp_data, 0);
        check_val("t6_rst_strlen", comp_strlen, 0);
        check_val("t6_rst_valid", res_valid, 0);
        check_val("t6_rst_pending", cfg_pending, 0);
        rst = 1'b0;
        in_valid = 1'b0; in_sop = 1'b0;
        tick;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
